pipe_hazard_unit: RTL and testbench

- Parametrised hazard, forwarding and flush controller for the in-order MIPS pipeline.
- Tracks in-flight register writers in a shift-register scoreboard spanning EX..WB.
- Issues registered forward selects, load-use stalls sized to the memory latency, and redirect flushes.
- Sits beside the ID/EX boundary. Replaces the hard-wired two-stage forwarding and the disabled stall logic in the CPU top.

---
 rtl/pipe_hazard_pkg.sv | 21 ++
 rtl/pipe_hazard_if.sv | 35 +++
 rtl/haz_scoreboard.sv | 63 ++++++
 rtl/pipe_hazard_unit.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// The scoreboard entry uses fixed field widths, so REG_AW must not exceed SB_RA_W.
package pipe_hazard_pkg;

    localparam int SB_RA_W     = 8;
    localparam int SB_AGE_W    = 3;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [SB_RA_W-1:0]  wrreg;
        logic                is_load;
        logic [SB_AGE_W-1:0] age;
    } sb_entry_t;

    // First position past EX from which a writer's result can be forwarded.
    function automatic int avail_idx(input logic is_load, input int load_lat);
        return is_load ? (1 + load_lat) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_if.sv
// ID-stage request and hazard-control response bundle for pipe_hazard_unit.
// The master side is the decode stage; the slave side is the hazard unit.
interface pipe_hazard_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int FW     = $clog2(DEPTH + 1)
);
    logic                         id_valid;
    logic [REG_AW-1:0]            id_rs;
    logic [REG_AW-1:0]            id_rt;
    logic                         id_use_rs;
    logic                         id_use_rt;
    logic                         id_wr_en;
    logic [REG_AW-1:0]            id_wrreg;
    logic                         id_is_load;
    logic                         redirect;
    logic                         stall;
    logic                         flush;
    logic [FW-1:0]                fwd_a;
    logic [FW-1:0]                fwd_b;
    logic [$clog2(DEPTH+1)-1:0]   inflight;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wrreg, id_is_load, redirect,
        input  stall, flush, fwd_a, fwd_b, inflight
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wrreg, id_is_load, redirect,
        output stall, flush, fwd_a, fwd_b, inflight
    );

endinterface

// File: rtl/haz_scoreboard.sv
// Shift-register scoreboard of in-flight register writers, index 0 = EX.
// Redirect invalidates entries younger than the resolving stage before shifting.
module haz_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 3,
    parameter int RESOLVE_IDX = 1,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    input  logic [REG_AW-1:0]          wrreg_in,
    input  logic                       is_load_in,
    input  logic                       redirect,
    output logic [DEPTH-1:0]           valid_vec,
    output logic [DEPTH*SB_RA_W-1:0]   wrreg_vec,
    output logic [DEPTH-1:0]           load_vec,
    output logic [DEPTH*SB_AGE_W-1:0]  age_vec,
    output logic [CW-1:0]              count
);

    sb_entry_t     entries     [DEPTH];
    sb_entry_t     entries_nxt [DEPTH];
    logic [CW-1:0] count_nxt;

    always_comb begin
        entries_nxt[0] = '{valid: issue, wrreg: SB_RA_W'(wrreg_in),
                           is_load: is_load_in, age: '0};
        for (int i = 1; i < DEPTH; i++) begin
            entries_nxt[i]     = entries[i-1];
            entries_nxt[i].age = entries[i-1].age + SB_AGE_W'(1);
            if (redirect && (i - 1) < RESOLVE_IDX)
                entries_nxt[i].valid = 1'b0;
        end
        count_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            count_nxt = count_nxt + CW'(entries_nxt[i].valid);
    end

    // Ages are preset to the entry index so they stay aligned through bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '{valid: 1'b0, wrreg: '0, is_load: 1'b0,
                                age: SB_AGE_W'(i)};
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= entries_nxt[i];
            count <= count_nxt;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign valid_vec[g]                        = entries[g].valid;
        assign wrreg_vec[g*SB_RA_W +: SB_RA_W]     = entries[g].wrreg;
        assign load_vec[g]                         = entries[g].is_load;
        assign age_vec[g*SB_AGE_W +: SB_AGE_W]     = entries[g].age;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller for the in-order pipeline.
// Optional saturating stall/flush counters: define PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_LAT    = 1,
    parameter int RESOLVE_IDX = 1,
    parameter int FW          = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    pipe_hazard_if.slave   bus
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [31:0]    flush_cnt
`endif
);

    logic [DEPTH-1:0]           sb_valid;
    logic [DEPTH*SB_RA_W-1:0]   sb_wrreg;
    logic [DEPTH-1:0]           sb_load;
    logic [DEPTH*SB_AGE_W-1:0]  sb_age;
    logic [FW-1:0]              sb_count;

    logic [REG_AW-1:0]          src_reg [2];
    logic                       src_use [2];
    logic                       src_haz [2];
    logic [FW-1:0]              src_sel [2];
    logic                       found;
    logic [SB_AGE_W-1:0]        hit_age;
    logic                       hit_load;
    int                         pos;

    logic                       stall;
    logic                       issue;
    logic [FW-1:0]              fwd_a_q;
    logic [FW-1:0]              fwd_b_q;

    haz_scoreboard #(
        .REG_AW      (REG_AW),
        .DEPTH       (DEPTH),
        .RESOLVE_IDX (RESOLVE_IDX),
        .CW          (FW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .wrreg_in   (bus.id_wrreg),
        .is_load_in (bus.id_is_load),
        .redirect   (bus.redirect),
        .valid_vec  (sb_valid),
        .wrreg_vec  (sb_wrreg),
        .load_vec   (sb_load),
        .age_vec    (sb_age),
        .count      (sb_count)
    );

    always_comb begin
        src_reg[0] = bus.id_rs;
        src_reg[1] = bus.id_rt;
        src_use[0] = bus.id_valid & bus.id_use_rs;
        src_use[1] = bus.id_valid & bus.id_use_rt;
    end

    // Scanning oldest to youngest lets the youngest matching writer win.
    always_comb begin
        found    = 1'b0;
        hit_age  = '0;
        hit_load = 1'b0;
        pos      = 0;
        for (int s = 0; s < 2; s++) begin
            src_haz[s] = 1'b0;
            src_sel[s] = FW'(FWD_REGFILE);
            found      = 1'b0;
            hit_age    = '0;
            hit_load   = 1'b0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (sb_valid[i] &&
                    sb_wrreg[i*SB_RA_W +: SB_RA_W] == SB_RA_W'(src_reg[s])) begin
                    found    = 1'b1;
                    hit_age  = sb_age[i*SB_AGE_W +: SB_AGE_W];
                    hit_load = sb_load[i];
                end
            end
            pos = int'(hit_age) + 1;
            if (src_use[s] && src_reg[s] != '0 && found) begin
                if (pos < avail_idx(hit_load, LOAD_LAT))
                    src_haz[s] = 1'b1;
                else if (pos < DEPTH)
                    src_sel[s] = FW'(pos + 1);
            end
        end
    end

    assign stall = (src_haz[0] | src_haz[1]) & ~bus.redirect;
    assign issue = bus.id_valid & bus.id_wr_en & (bus.id_wrreg != '0)
                 & ~stall & ~bus.redirect;

    // A stalled, flushed or empty ID slot puts a bubble into EX, which reads nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q <= FW'(FWD_REGFILE);
            fwd_b_q <= FW'(FWD_REGFILE);
        end else if (stall || bus.redirect || !bus.id_valid) begin
            fwd_a_q <= FW'(FWD_REGFILE);
            fwd_b_q <= FW'(FWD_REGFILE);
        end else begin
            fwd_a_q <= src_sel[0];
            fwd_b_q <= src_sel[1];
        end
    end

    assign bus.stall    = stall;
    assign bus.flush    = bus.redirect;
    assign bus.fwd_a    = fwd_a_q;
    assign bus.fwd_b    = fwd_b_q;
    assign bus.inflight = sb_count;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (bus.redirect && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed testbench for pipe_hazard_unit: a DEPTH=3/LOAD_LAT=1 instance and
// a DEPTH=4/LOAD_LAT=2 instance, each checked against hand-computed values.
module tb_pipe_hazard_unit;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_if #(.REG_AW(5), .DEPTH(3)) ha ();
    pipe_hazard_if #(.REG_AW(5), .DEPTH(4)) hb ();

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    pipe_hazard_unit #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(1), .RESOLVE_IDX(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ha)
`ifdef PIPE_HAZARD_PERF_CNT_EN
        , .stall_cnt (a_stall_cnt), .flush_cnt (a_flush_cnt)
`endif
    );

    pipe_hazard_unit #(.REG_AW(5), .DEPTH(4), .LOAD_LAT(2), .RESOLVE_IDX(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (hb)
`ifdef PIPE_HAZARD_PERF_CNT_EN
        , .stall_cnt (b_stall_cnt), .flush_cnt (b_flush_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic we,
                           input logic [4:0] wr, input logic ld, input logic rd);
        ha.id_valid   = v;
        ha.id_rs      = rs;
        ha.id_rt      = rt;
        ha.id_use_rs  = urs;
        ha.id_use_rt  = urt;
        ha.id_wr_en   = we;
        ha.id_wrreg   = wr;
        ha.id_is_load = ld;
        ha.redirect   = rd;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urs, input logic urt, input logic we,
                           input logic [4:0] wr, input logic ld, input logic rd);
        hb.id_valid   = v;
        hb.id_rs      = rs;
        hb.id_rt      = rt;
        hb.id_use_rs  = urs;
        hb.id_use_rt  = urt;
        hb.id_wr_en   = we;
        hb.id_wrreg   = wr;
        hb.id_is_load = ld;
        hb.redirect   = rd;
    endtask

    task automatic drain();
        drive_a(F, 5'd0, 5'd0, F, F, F, 5'd0, F, F);
        drive_b(F, 5'd0, 5'd0, F, F, F, 5'd0, F, F);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_a(F, 5'd0, 5'd0, F, F, F, 5'd0, F, F);
        drive_b(F, 5'd0, 5'd0, F, F, F, 5'd0, F, F);
        #2;
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %0b want 0", ha.stall); end
        n_checks++;
        if (ha.flush !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flush: got %0b want 0", ha.flush); end
        n_checks++;
        if (ha.fwd_a !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_fwd_a: got %0d want 0", ha.fwd_a); end
        n_checks++;
        if (ha.fwd_b !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_fwd_b: got %0d want 0", ha.fwd_b); end
        n_checks++;
        if (ha.inflight !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_inflight: got %0d want 0", ha.inflight); end
        n_checks++;
        if (hb.inflight !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_inflight_b: got %0d want 0", hb.inflight); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // add $1,$2,$3 ; add $4,$1,$1
    task automatic test_alu_forward();
        drive_a(T, 5'd2, 5'd3, T, T, T, 5'd1, F, F);
        #1;
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_first_stall: got %0b want 0", ha.stall); end
        tick();
        n_checks++;
        if (ha.inflight !== 2'd1) begin n_fail++; $display("[TB] FAIL alu_inflight1: got %0d want 1", ha.inflight); end
        drive_a(T, 5'd1, 5'd1, T, T, T, 5'd4, F, F);
        #1;
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_dep_stall: got %0b want 0", ha.stall); end
        tick();
        n_checks++;
        if (ha.fwd_a !== 2'd2) begin n_fail++; $display("[TB] FAIL alu_fwd_a: got %0d want 2", ha.fwd_a); end
        n_checks++;
        if (ha.fwd_b !== 2'd2) begin n_fail++; $display("[TB] FAIL alu_fwd_b: got %0d want 2", ha.fwd_b); end
        n_checks++;
        if (ha.inflight !== 2'd2) begin n_fail++; $display("[TB] FAIL alu_inflight2: got %0d want 2", ha.inflight); end
        drain();
        n_checks++;
        if (ha.inflight !== 2'd0) begin n_fail++; $display("[TB] FAIL alu_drained: got %0d want 0", ha.inflight); end
    endtask

    // lw $1,16($3) ; add $2,$1,$0
    task automatic test_load_use();
        drive_a(T, 5'd3, 5'd0, T, F, T, 5'd1, T, F);
        tick();
        drive_a(T, 5'd1, 5'd0, T, T, T, 5'd2, F, F);
        #1;
        n_checks++;
        if (ha.stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_stall_c0: got %0b want 1", ha.stall); end
        tick();
        n_checks++;
        if (ha.inflight !== 2'd1) begin n_fail++; $display("[TB] FAIL lu_inflight_bubble: got %0d want 1", ha.inflight); end
        n_checks++;
        if (ha.fwd_a !== 2'd0) begin n_fail++; $display("[TB] FAIL lu_fwd_a_bubble: got %0d want 0", ha.fwd_a); end
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_stall_c1: got %0b want 0", ha.stall); end
        tick();
        n_checks++;
        if (ha.fwd_a !== 2'd3) begin n_fail++; $display("[TB] FAIL lu_fwd_a: got %0d want 3", ha.fwd_a); end
        n_checks++;
        if (ha.fwd_b !== 2'd0) begin n_fail++; $display("[TB] FAIL lu_fwd_b: got %0d want 0", ha.fwd_b); end
        n_checks++;
        if (ha.inflight !== 2'd2) begin n_fail++; $display("[TB] FAIL lu_inflight: got %0d want 2", ha.inflight); end
        drain();
    endtask

    // Same load-use pair on the DEPTH=4, LOAD_LAT=2 instance.
    task automatic test_load_use_lat2();
        drive_b(T, 5'd3, 5'd0, T, F, T, 5'd1, T, F);
        tick();
        drive_b(T, 5'd1, 5'd0, T, T, T, 5'd2, F, F);
        #1;
        n_checks++;
        if (hb.stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lat2_stall_c0: got %0b want 1", hb.stall); end
        tick();
        n_checks++;
        if (hb.stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lat2_stall_c1: got %0b want 1", hb.stall); end
        n_checks++;
        if (hb.fwd_a !== 3'd0) begin n_fail++; $display("[TB] FAIL lat2_fwd_bubble: got %0d want 0", hb.fwd_a); end
        tick();
        n_checks++;
        if (hb.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL lat2_stall_c2: got %0b want 0", hb.stall); end
        tick();
        n_checks++;
        if (hb.fwd_a !== 3'd4) begin n_fail++; $display("[TB] FAIL lat2_fwd_a: got %0d want 4", hb.fwd_a); end
        n_checks++;
        if (hb.inflight !== 3'd2) begin n_fail++; $display("[TB] FAIL lat2_inflight: got %0d want 2", hb.inflight); end
        drain();
    endtask

    // addi $0,$0,5 ; add $5,$0,$0
    task automatic test_zero_reg();
        drive_a(T, 5'd0, 5'd0, T, F, T, 5'd0, F, F);
        tick();
        n_checks++;
        if (ha.inflight !== 2'd0) begin n_fail++; $display("[TB] FAIL zero_inflight: got %0d want 0", ha.inflight); end
        drive_a(T, 5'd0, 5'd0, T, T, T, 5'd5, F, F);
        #1;
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_stall: got %0b want 0", ha.stall); end
        tick();
        n_checks++;
        if (ha.fwd_a !== 2'd0) begin n_fail++; $display("[TB] FAIL zero_fwd_a: got %0d want 0", ha.fwd_a); end
        n_checks++;
        if (ha.fwd_b !== 2'd0) begin n_fail++; $display("[TB] FAIL zero_fwd_b: got %0d want 0", ha.fwd_b); end
        drain();
    endtask

    // add $9 ; lw $7 ; then beq resolves taken while add $8,$7,$7 sits in ID.
    task automatic test_redirect();
        drive_a(T, 5'd2, 5'd3, T, T, T, 5'd9, F, F);
        tick();
        drive_a(T, 5'd3, 5'd0, T, F, T, 5'd7, T, F);
        tick();
        drive_a(T, 5'd7, 5'd7, T, T, T, 5'd8, F, T);
        #1;
        n_checks++;
        if (ha.flush !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_flush: got %0b want 1", ha.flush); end
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_stall: got %0b want 0", ha.stall); end
        tick();
        n_checks++;
        if (ha.inflight !== 2'd1) begin n_fail++; $display("[TB] FAIL redir_inflight: got %0d want 1", ha.inflight); end
        n_checks++;
        if (ha.fwd_a !== 2'd0) begin n_fail++; $display("[TB] FAIL redir_fwd_a: got %0d want 0", ha.fwd_a); end
        drive_a(F, 5'd0, 5'd0, F, F, F, 5'd0, F, F);
        #1;
        n_checks++;
        if (ha.flush !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_flush_clear: got %0b want 0", ha.flush); end
        drain();
    endtask

    // Youngest writer wins, and a writer already in WB is served by the register file.
    task automatic test_back_to_back();
        drive_a(T, 5'd3, 5'd0, T, F, T, 5'd1, T, F);
        tick();
        drive_a(T, 5'd2, 5'd3, T, T, T, 5'd1, F, F);
        tick();
        drive_a(T, 5'd1, 5'd1, T, T, T, 5'd6, F, F);
        #1;
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_stall: got %0b want 0", ha.stall); end
        tick();
        n_checks++;
        if (ha.fwd_a !== 2'd2) begin n_fail++; $display("[TB] FAIL prio_fwd_a: got %0d want 2", ha.fwd_a); end
        n_checks++;
        if (ha.fwd_b !== 2'd2) begin n_fail++; $display("[TB] FAIL prio_fwd_b: got %0d want 2", ha.fwd_b); end
        drain();
        drive_a(T, 5'd2, 5'd3, T, T, T, 5'd1, F, F);
        tick();
        drive_a(F, 5'd0, 5'd0, F, F, F, 5'd0, F, F);
        tick();
        tick();
        drive_a(T, 5'd1, 5'd0, T, T, T, 5'd6, F, F);
        #1;
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL wb_stall: got %0b want 0", ha.stall); end
        tick();
        n_checks++;
        if (ha.fwd_a !== 2'd0) begin n_fail++; $display("[TB] FAIL wb_fwd_a: got %0d want 0", ha.fwd_a); end
        drain();
    endtask

    // Reset pulsed while a load-use stall is active.
    task automatic test_reset_mid_stall();
        drive_a(T, 5'd3, 5'd0, T, F, T, 5'd1, T, F);
        tick();
        drive_a(T, 5'd1, 5'd0, T, T, T, 5'd2, F, F);
        #1;
        n_checks++;
        if (ha.stall !== 1'b1) begin n_fail++; $display("[TB] FAIL rms_stall_before: got %0b want 1", ha.stall); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL rms_stall_reset: got %0b want 0", ha.stall); end
        n_checks++;
        if (ha.inflight !== 2'd0) begin n_fail++; $display("[TB] FAIL rms_inflight: got %0d want 0", ha.inflight); end
        n_checks++;
        if (ha.fwd_a !== 2'd0 || ha.fwd_b !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL rms_fwd: got a=%0d b=%0d want 0 0", ha.fwd_a, ha.fwd_b);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ha.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL rms_stall_after: got %0b want 0", ha.stall); end
        tick();
        n_checks++;
        if (ha.fwd_a !== 2'd0) begin n_fail++; $display("[TB] FAIL rms_fwd_after: got %0d want 0", ha.fwd_a); end
        n_checks++;
        if (ha.inflight !== 2'd1) begin n_fail++; $display("[TB] FAIL rms_inflight_after: got %0d want 1", ha.inflight); end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_load_use_lat2();
        test_zero_reg();
        test_redirect();
        test_back_to_back();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
